// File: rtl/serial_operand_streamer_pkg.sv
// Shared types and helpers for the serial operand streamer.
// Holds the FSM state encoding and the bit-counter width function.
package serial_operand_streamer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Counter width: enough bits to index WIDTH bits, never zero.
    function automatic int cnt_width(input int w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register, one bit per shift.
// Ports: clk, rst (sync, high), load, shift, d[WIDTH-1:0], q_bit.
// Zeros are shifted in, so the register is empty once a word drains.
module piso_shift_reg #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             q_bit
);

    logic [WIDTH-1:0] r_sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr <= '0;
        end else if (load) begin
            r_sr <= d;
        end else if (shift) begin
            if (MSB_FIRST)
                r_sr <= r_sr << 1;
            else
                r_sr <= r_sr >> 1;
        end
    end

    assign q_bit = MSB_FIRST ? r_sr[WIDTH-1] : r_sr[0];

endmodule

// File: rtl/serial_operand_streamer.sv
// Serialises an operand pair (A, B) bit by bit for a serial comparator.
// Ports: clk, rst, in_valid/in_ready/in_a/in_b (parallel side),
//   out_valid/out_a/out_b/out_first/out_last, cmp_rst (serial side).
// Optional macro SERIAL_OPERAND_STREAMER_RESULT_EN adds cmp_less/eq/
//   greater inputs and res_valid/less/eq/greater captured outputs.
module serial_operand_streamer
    import serial_operand_streamer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    output logic             out_a,
    output logic             out_b,
    output logic             out_first,
    output logic             out_last,
    output logic             cmp_rst
`ifdef SERIAL_OPERAND_STREAMER_RESULT_EN
    ,
    input  logic             cmp_less,
    input  logic             cmp_eq,
    input  logic             cmp_greater,
    output logic             res_valid,
    output logic             res_less,
    output logic             res_eq,
    output logic             res_greater
`endif
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_valid;
    logic          r_first;
    logic          r_last;
    logic          r_cmp_rst;
    logic          w_xfer;
    logic          w_shift;

    assign in_ready = (r_state == IDLE) & ~rst;
    assign w_xfer   = in_valid & in_ready;
    assign w_shift  = (r_state == SHIFT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_valid   <= 1'b0;
            r_first   <= 1'b0;
            r_last    <= 1'b0;
            r_cmp_rst <= 1'b1;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_state   <= SHIFT;
                        r_cnt     <= '0;
                        r_valid   <= 1'b1;
                        r_first   <= 1'b1;
                        r_last    <= (LAST == '0);
                        r_cmp_rst <= 1'b0;
                    end
                end
                SHIFT: begin
                    // Always drop back to IDLE after the last bit so
                    // the comparator sees at least one clear cycle.
                    if (r_cnt == LAST) begin
                        r_state   <= IDLE;
                        r_cnt     <= '0;
                        r_valid   <= 1'b0;
                        r_first   <= 1'b0;
                        r_last    <= 1'b0;
                        r_cmp_rst <= 1'b1;
                    end else begin
                        r_cnt   <= r_cnt + CW'(1);
                        r_first <= 1'b0;
                        r_last  <= ((r_cnt + CW'(1)) == LAST);
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_cmp_rst <= 1'b1;
                end
            endcase
        end
    end

    // Shift registers drain to zero, so out_a/out_b read 0 in IDLE.
    piso_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_sr_a (
        .clk   (clk),
        .rst   (rst),
        .load  (w_xfer),
        .shift (w_shift),
        .d     (in_a),
        .q_bit (out_a)
    );

    piso_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_sr_b (
        .clk   (clk),
        .rst   (rst),
        .load  (w_xfer),
        .shift (w_shift),
        .d     (in_b),
        .q_bit (out_b)
    );

    assign out_valid = r_valid;
    assign out_first = r_first;
    assign out_last  = r_last;
    assign cmp_rst   = r_cmp_rst;

`ifdef SERIAL_OPERAND_STREAMER_RESULT_EN
    logic r_res_valid;
    logic r_res_less;
    logic r_res_eq;
    logic r_res_greater;

    // Comparator verdict is final during the last bit pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_valid   <= 1'b0;
            r_res_less    <= 1'b0;
            r_res_eq      <= 1'b0;
            r_res_greater <= 1'b0;
        end else begin
            r_res_valid <= r_last;
            if (r_last) begin
                r_res_less    <= cmp_less;
                r_res_eq      <= cmp_eq;
                r_res_greater <= cmp_greater;
            end
        end
    end

    assign res_valid   = r_res_valid;
    assign res_less    = r_res_less;
    assign res_eq      = r_res_eq;
    assign res_greater = r_res_greater;
`else
    // Result capture is not built in this configuration.
`endif

endmodule

// File: tb/tb_serial_operand_streamer.sv
// Self-checking bench for serial_operand_streamer.
// Three instances: W8 MSB-first, W8 LSB-first, W1.
module tb_serial_operand_streamer;

    logic       clk;
    logic       rst;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       iv0, iv1, iv2;
    logic       ir0, ir1, ir2;
    logic       ov0, ov1, ov2;
    logic       oa0, oa1, oa2;
    logic       ob0, ob1, ob2;
    logic       of0, of1, of2;
    logic       ol0, ol1, ol2;
    logic       cr0, cr1, cr2;
    logic       cmp_less, cmp_eq, cmp_greater;
`ifdef SERIAL_OPERAND_STREAMER_RESULT_EN
    logic       rv0, rl0, re0, rg0;
    logic       rv1, rl1, re1, rg1;
    logic       rv2, rl2, re2, rg2;
`endif

    int total = 0;
    int bad   = 0;

    serial_operand_streamer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0),
        .in_a(in_a), .in_b(in_b), .out_valid(ov0), .out_a(oa0),
        .out_b(ob0), .out_first(of0), .out_last(ol0), .cmp_rst(cr0)
`ifdef SERIAL_OPERAND_STREAMER_RESULT_EN
        , .cmp_less(cmp_less), .cmp_eq(cmp_eq),
        .cmp_greater(cmp_greater), .res_valid(rv0), .res_less(rl0),
        .res_eq(re0), .res_greater(rg0)
`endif
    );

    serial_operand_streamer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1),
        .in_a(in_a), .in_b(in_b), .out_valid(ov1), .out_a(oa1),
        .out_b(ob1), .out_first(of1), .out_last(ol1), .cmp_rst(cr1)
`ifdef SERIAL_OPERAND_STREAMER_RESULT_EN
        , .cmp_less(cmp_less), .cmp_eq(cmp_eq),
        .cmp_greater(cmp_greater), .res_valid(rv1), .res_less(rl1),
        .res_eq(re1), .res_greater(rg1)
`endif
    );

    serial_operand_streamer #(.WIDTH(1), .MSB_FIRST(1'b1)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2),
        .in_a(in_a[0:0]), .in_b(in_b[0:0]), .out_valid(ov2),
        .out_a(oa2), .out_b(ob2), .out_first(of2), .out_last(ol2),
        .cmp_rst(cr2)
`ifdef SERIAL_OPERAND_STREAMER_RESULT_EN
        , .cmp_less(cmp_less), .cmp_eq(cmp_eq),
        .cmp_greater(cmp_greater), .res_valid(rv2), .res_less(rl2),
        .res_eq(re2), .res_greater(rg2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packed view {in_ready, valid, a, b, first, last, cmp_rst}
    task automatic smp(input int d, output logic [6:0] s);
        case (d)
            0:       s = {ir0, ov0, oa0, ob0, of0, ol0, cr0};
            1:       s = {ir1, ov1, oa1, ob1, of1, ol1, cr1};
            default: s = {ir2, ov2, oa2, ob2, of2, ol2, cr2};
        endcase
    endtask

    task automatic setv(input int d, input logic v);
        case (d)
            0:       iv0 = v;
            1:       iv1 = v;
            default: iv2 = v;
        endcase
    endtask

    function automatic int wd(input int d);
        return (d == 2) ? 1 : 8;
    endfunction

    function automatic int ms(input int d);
        return (d == 1) ? 0 : 1;
    endfunction

    // Called on a negedge with the DUT idle; returns on the negedge of
    // the idle cycle following the word. chain keeps in_valid high so
    // the next call's word is accepted in that idle cycle.
    task automatic stream(input int d, input logic [7:0] a,
                          input logic [7:0] b, input bit chain,
                          input int cf);
        logic [6:0] s;
        logic [2:0] c;
        int w;
        int msb;
        int idx;
        w   = wd(d);
        msb = ms(d);
        c   = 3'b000;
        in_a = a;
        in_b = b;
        setv(d, 1'b1);
        smp(d, s);
        chk("idle_ready", s[6], 1);
        chk("idle_valid", s[5], 0);
        chk("idle_cmprst", s[0], 1);
        for (int k = 0; k < w; k++) begin
            @(negedge clk);
            // Inputs wander during SHIFT; the word must be unaffected.
            setv(d, chain ? 1'b1 : 1'($urandom_range(0, 1)));
            in_a = 8'($urandom);
            in_b = 8'($urandom);
            idx = msb ? (w - 1 - k) : k;
            smp(d, s);
            chk("shift_ready", s[6], 0);
            chk("shift_valid", s[5], 1);
            chk("bit_a", s[4], a[idx]);
            chk("bit_b", s[3], b[idx]);
            chk("first", s[2], (k == 0));
            chk("last", s[1], (k == w - 1));
            chk("shift_cmprst", s[0], 0);
            if (k == w - 1) begin
                c = (cf < 0) ? 3'($urandom) : 3'(cf);
                cmp_less    = c[2];
                cmp_eq      = c[1];
                cmp_greater = c[0];
            end
        end
        @(negedge clk);
        if (!chain) setv(d, 1'b0);
        smp(d, s);
        chk("gap_ready", s[6], 1);
        chk("gap_valid", s[5], 0);
        chk("gap_ab", s[4:3], 0);
        chk("gap_flags", s[2:1], 0);
        chk("gap_cmprst", s[0], 1);
`ifdef SERIAL_OPERAND_STREAMER_RESULT_EN
        if (d == 0) begin
            chk("res_valid", rv0, 1);
            chk("res_vals", {rl0, re0, rg0}, c);
        end
`else
        if (c[0] === 1'bx) chk("cmp_sample", c, 0);
`endif
    endtask

    initial begin
        logic [6:0] s;
        bit ch;
        rst = 1'b1;
        iv0 = 1'b0;
        iv1 = 1'b0;
        iv2 = 1'b0;
        in_a = 8'h00;
        in_b = 8'h00;
        cmp_less = 1'b0;
        cmp_eq = 1'b0;
        cmp_greater = 1'b0;
        repeat (2) @(negedge clk);
        smp(0, s);
        chk("rst_ready", s[6], 0);
        chk("rst_valid", s[5], 0);
        chk("rst_flags", s[2:1], 0);
        chk("rst_cmprst", s[0], 1);
`ifdef SERIAL_OPERAND_STREAMER_RESULT_EN
        chk("rst_res", {rv0, rl0, re0, rg0}, 0);
`endif
        rst = 1'b0;
        @(negedge clk);
        smp(0, s);
        chk("post_rst_ready", s[6], 1);

        // Basic MSB-first word
        stream(0, 8'hA5, 8'h5A, 1'b0, -1);
        // Back-to-back words with in_valid held
        stream(0, 8'h01, 8'h02, 1'b1, -1);
        stream(0, 8'hFF, 8'h00, 1'b0, -1);
        // LSB-first
        stream(1, 8'h01, 8'h80, 1'b0, -1);

`ifdef SERIAL_OPERAND_STREAMER_RESULT_EN
        stream(0, 8'h3C, 8'h3C, 1'b0, 3'b010);
        @(negedge clk);
        chk("res_pulse_end", rv0, 0);
        chk("res_eq_hold", {rl0, re0, rg0}, 3'b010);
`endif

        // Reset in the middle of a word
        in_a = 8'hC3;
        in_b = 8'h3C;
        setv(0, 1'b1);
        @(negedge clk);
        setv(0, 1'b0);
        repeat (2) @(negedge clk);
        smp(0, s);
        chk("pre_abort_valid", s[5], 1);
        chk("pre_abort_last", s[1], 0);
        rst = 1'b1;
        setv(0, 1'b1);
        #1;
        smp(0, s);
        chk("rst_blocks_ready", s[6], 0);
        @(negedge clk);
        smp(0, s);
        chk("abort_ready", s[6], 0);
        chk("abort_valid", s[5], 0);
        chk("abort_last", s[1], 0);
        chk("abort_cmprst", s[0], 1);
        rst = 1'b0;
        setv(0, 1'b0);
        @(negedge clk);
        smp(0, s);
        chk("after_rst_ready", s[6], 1);
        chk("after_rst_valid", s[5], 0);
        chk("after_rst_last", s[1], 0);

        // Single-bit width
        stream(2, 8'h01, 8'h00, 1'b0, -1);

        // Random words on every instance, random chaining and gaps
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 5; i++) begin
                ch = (i < 4) && ($urandom_range(0, 1) == 1);
                stream(d, 8'($urandom), 8'($urandom), ch, -1);
                if (!ch) repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
